// File: rtl/pico_crypto_mailbox_pkg.sv
// Shared definitions for the PicoRV32 crypto mailbox.
// Contents: FSM state encoding, register word offsets, and CTRL/STATUS bit positions.
package pico_crypto_mailbox_pkg;

  // Mailbox sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FINISH  = 2'd2
  } state_e;

  // Byte offsets inside the 256-byte window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_CYCCNT = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h10;
  localparam logic [7:0] OFF_TEXT   = 8'h20;
  localparam logic [7:0] OFF_CIPHER = 8'h30;

  // CTRL/STATUS bit positions
  // DONE (write) shares bit 0 with PENDING (read)
  localparam int CTRL_PENDING_BIT  = 0;
  localparam int CTRL_DONE_BIT     = 0;
  localparam int CTRL_BUSY_BIT     = 1;
  localparam int CTRL_OVERRUN_BIT  = 2;

  // Each field occupies a 16-byte region of up to four 32-bit words
  localparam int MAX_WORDS = 4;

endpackage

// File: rtl/pico_crypto_mailbox_regfile.sv
// Shadow storage for the crypto mailbox.
// Holds the key and plaintext snapshots and the firmware-written cipher words.
// Provides the byte-strobe write path for the cipher words and the combinational
// word read mux; the top level registers the mux output onto the bus.
module pico_crypto_mailbox_regfile
  import pico_crypto_mailbox_pkg::*;
#(
  parameter int KEY_WIDTH  = 128,
  parameter int TEXT_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  capture,       // snapshot key/textin, clear cipher
  input  logic                  wr_en,         // accepted bus write this cycle
  input  logic [5:0]            word_addr,     // mem_addr[7:2]
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic [2:0]            ctrl_status,
  input  logic [31:0]           cyccnt,
  input  logic [KEY_WIDTH-1:0]  key,
  input  logic [TEXT_WIDTH-1:0] textin,
  output logic [31:0]           rd_data,
  output logic [TEXT_WIDTH-1:0] cipher_shadow
);

  localparam int KEY_WORDS  = KEY_WIDTH / 32;
  localparam int TEXT_WORDS = TEXT_WIDTH / 32;

  logic [31:0] key_words    [MAX_WORDS];
  logic [31:0] text_words   [MAX_WORDS];
  logic [31:0] cipher_words [MAX_WORDS];

  logic cipher_field_hit;
  assign cipher_field_hit = wr_en && (word_addr[5:2] == OFF_CIPHER[7:4]);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_WORDS; gi++) begin : g_word
      if (gi < KEY_WORDS) begin : g_key
        logic [31:0] key_reg;
        // Key snapshot taken when a start is accepted
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn)      key_reg <= '0;
          else if (capture) key_reg <= key[32*gi +: 32];
        end
        assign key_words[gi] = key_reg;
      end else begin : g_key_absent
        assign key_words[gi] = '0;
      end

      if (gi < TEXT_WORDS) begin : g_text
        logic [31:0] text_reg;
        logic [31:0] cipher_reg;
        // Plaintext snapshot taken when a start is accepted
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn)      text_reg <= '0;
          else if (capture) text_reg <= textin[32*gi +: 32];
        end
        // Cipher word: cleared on entering PENDING, otherwise byte-strobe writes
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            cipher_reg <= '0;
          end else if (capture) begin
            cipher_reg <= '0;
          end else if (cipher_field_hit && (word_addr[1:0] == 2'(gi))) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) cipher_reg[8*b +: 8] <= wdata[8*b +: 8];
            end
          end
        end
        assign text_words[gi]   = text_reg;
        assign cipher_words[gi] = cipher_reg;
        assign cipher_shadow[32*gi +: 32] = cipher_reg;
      end else begin : g_text_absent
        assign text_words[gi]   = '0;
        assign cipher_words[gi] = '0;
      end
    end
  endgenerate

  // Word read mux; unmapped offsets and words beyond the field width read 0
  always_comb begin
    rd_data = '0;
    if (word_addr == OFF_CTRL[7:2]) begin
      rd_data = {29'd0, ctrl_status};
    end else if (word_addr == OFF_CYCCNT[7:2]) begin
      rd_data = cyccnt;
    end else if (word_addr[5:2] == OFF_KEY[7:4]) begin
      rd_data = key_words[word_addr[1:0]];
    end else if (word_addr[5:2] == OFF_TEXT[7:4]) begin
      rd_data = text_words[word_addr[1:0]];
    end else if (word_addr[5:2] == OFF_CIPHER[7:4]) begin
      rd_data = cipher_words[word_addr[1:0]];
    end
  end

endmodule

// File: rtl/pico_crypto_mailbox.sv
// PicoRV32 native-bus mailbox that lets firmware stand in for the CW305 crypto core.
// A start pulse snapshots key/textin; firmware reads them, writes the cipher
// words and sets CTRL.DONE, after which cipherout is updated and done pulses.
// Optional build macro: MAILBOX_CYCCNT_EN adds a saturating PENDING-cycle counter
// at offset 0x04 (reads 0 when the macro is undefined).
// KEY_WIDTH and TEXT_WIDTH must be multiples of 32 no larger than 128.
module pico_crypto_mailbox
  import pico_crypto_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter int          KEY_WIDTH  = 128,
  parameter int          TEXT_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  output logic                  sel,
  input  logic                  start,
  input  logic [KEY_WIDTH-1:0]  key,
  input  logic [TEXT_WIDTH-1:0] textin,
  output logic [TEXT_WIDTH-1:0] cipherout,
  output logic                  done,
  output logic                  busy,
  output logic                  irq
);

  state_e                state_reg, state_next;
  logic                  mem_ready_reg;
  logic [31:0]           mem_rdata_reg;
  logic                  overrun_reg;
  logic                  done_reg;
  logic [TEXT_WIDTH-1:0] cipherout_reg;
  logic [31:0]           cyccnt;
  logic [31:0]           rd_data;
  logic [TEXT_WIDTH-1:0] cipher_shadow;
  logic [2:0]            ctrl_status;

  logic bus_hit, wr_hit, ctrl_wr, done_wr, overrun_clr;
  logic start_accept, start_overrun;
  logic unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  // Address decode is purely combinational so the system read mux can use it
  assign sel = (mem_addr[31:8] == BASE_ADDR[31:8]);

  // A hit is taken only when no acknowledge is outstanding, so a held request
  // is acknowledged every other cycle
  assign bus_hit     = mem_valid && sel && !mem_ready_reg;
  assign wr_hit      = bus_hit && (mem_wstrb != 4'b0000);
  assign ctrl_wr     = wr_hit && mem_wstrb[0] && (mem_addr[7:2] == OFF_CTRL[7:2]);
  assign done_wr     = ctrl_wr && mem_wdata[CTRL_DONE_BIT];
  assign overrun_clr = ctrl_wr && mem_wdata[CTRL_OVERRUN_BIT];

  assign start_accept  = start && (state_reg == ST_IDLE);
  assign start_overrun = start && (state_reg != ST_IDLE);

  // busy/irq stay up through FINISH and fall together with the done pulse edge
  assign busy = (state_reg != ST_IDLE);
  assign irq  = (state_reg != ST_IDLE);

  assign mem_ready = mem_ready_reg;
  assign mem_rdata = mem_rdata_reg;
  assign done      = done_reg;
  assign cipherout = cipherout_reg;

  // Status word seen at CTRL reads
  always_comb begin
    ctrl_status = '0;
    ctrl_status[CTRL_PENDING_BIT]  = (state_reg == ST_PENDING);
    ctrl_status[CTRL_BUSY_BIT]     = busy;
    ctrl_status[CTRL_OVERRUN_BIT]  = overrun_reg;
  end

  // Next-state logic; a DONE write outside PENDING has no effect
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start)   state_next = ST_PENDING;
      ST_PENDING: if (done_wr) state_next = ST_FINISH;
      ST_FINISH:               state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Bus acknowledge and read data; read data is sampled before this edge's writes land
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_reg <= 1'b0;
      mem_rdata_reg <= '0;
    end else begin
      mem_ready_reg <= bus_hit;
      if (bus_hit) mem_rdata_reg <= rd_data;
    end
  end

  // Sticky OVERRUN; a coincident start wins over a firmware clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            overrun_reg <= 1'b0;
    else if (start_overrun) overrun_reg <= 1'b1;
    else if (overrun_clr)   overrun_reg <= 1'b0;
  end

  // Completion: publish the cipher shadow and pulse done while leaving FINISH
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done_reg      <= 1'b0;
      cipherout_reg <= '0;
    end else begin
      done_reg <= (state_reg == ST_FINISH);
      if (state_reg == ST_FINISH) cipherout_reg <= cipher_shadow;
    end
  end

`ifdef MAILBOX_CYCCNT_EN
  logic [31:0] cyccnt_reg;
  // Firmware latency counter: cleared on entry, counts PENDING cycles, saturates
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyccnt_reg <= '0;
    end else if (start_accept) begin
      cyccnt_reg <= '0;
    end else if ((state_reg == ST_PENDING) && (cyccnt_reg != 32'hFFFF_FFFF)) begin
      cyccnt_reg <= cyccnt_reg + 32'd1;
    end
  end
  assign cyccnt = cyccnt_reg;
`else
  assign cyccnt = '0;
`endif

  pico_crypto_mailbox_regfile #(
    .KEY_WIDTH  (KEY_WIDTH),
    .TEXT_WIDTH (TEXT_WIDTH)
  ) u_regfile (
    .clk           (clk),
    .resetn        (resetn),
    .capture       (start_accept),
    .wr_en         (wr_hit),
    .word_addr     (mem_addr[7:2]),
    .wdata         (mem_wdata),
    .wstrb         (mem_wstrb),
    .ctrl_status   (ctrl_status),
    .cyccnt        (cyccnt),
    .key           (key),
    .textin        (textin),
    .rd_data       (rd_data),
    .cipher_shadow (cipher_shadow)
  );

endmodule

// File: tb/tb_pico_crypto_mailbox.sv
// Self-checking bench for pico_crypto_mailbox.
// Bus accesses push their expected read data into a scoreboard queue and done
// completions push the expected cipherout; monitor processes pop and compare
// whenever mem_ready or done is seen.
module tb_pico_crypto_mailbox;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         mem_valid = 1'b0;
  logic [31:0]  mem_addr = 32'h0;
  logic [31:0]  mem_wdata = 32'h0;
  logic [3:0]   mem_wstrb = 4'h0;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         sel;
  logic         start = 1'b0;
  logic [127:0] key = 128'h0;
  logic [127:0] textin = 128'h0;
  logic [127:0] cipherout;
  logic         done;
  logic         busy;
  logic         irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    string       name;
  } sb_t;

  sb_t          sb_q[$];
  logic [127:0] done_q[$];

  always #5 clk = ~clk;

  pico_crypto_mailbox dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sel       (sel),
    .start     (start),
    .key       (key),
    .textin    (textin),
    .cipherout (cipherout),
    .done      (done),
    .busy      (busy),
    .irq       (irq)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Bus read monitor
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=1 required=0");
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        $display("BUS %s rdata=%h", e.name, mem_rdata);
        if (e.chk) check(e.name, {96'h0, mem_rdata}, {96'h0, e.data});
      end
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        logic [127:0] exp_c;
        exp_c = done_q.pop_front();
        $display("DONE cipherout=%h", cipherout);
        check("done_cipherout", cipherout, exp_c);
      end
    end
  end

  // One bus access lasting exactly one request cycle
  task automatic bus(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] ws,
                     input logic [31:0] exp, input string nm, input logic with_start = 1'b0);
    sb_t e;
    e.chk = (ws == 4'h0);
    e.data = exp;
    e.name = nm;
    sb_q.push_back(e);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE | {24'h0, off};
    mem_wdata = wd;
    mem_wstrb = ws;
    if (with_start) start = 1'b1;
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    start     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
    bus(off, 32'h0, 4'h0, exp, nm);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] ws, input string nm);
    bus(off, wd, ws, 32'h0, nm);
  endtask

  task automatic pulse_start(input logic [127:0] k, input logic [127:0] t);
    @(negedge clk);
    key = k;
    textin = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with start held high
    #2;
    resetn = 1'b0;
    start  = 1'b1;
    key    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    textin = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    repeat (3) @(negedge clk);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_irq", {127'h0, irq}, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    check("rst_mem_ready", {127'h0, mem_ready}, 128'h0);
    check("rst_mem_rdata", {96'h0, mem_rdata}, 128'h0);
    check("rst_cipherout", cipherout, 128'h0);
    check("rst_sel", {127'h0, sel}, 128'h0);
    start  = 1'b0;
    resetn = 1'b1;

    // First start after reset
    pulse_start(128'h000102030405060708090A0B0C0D0E0F, 128'hFFEEDDCCBBAA99887766554433221100);
    check("start_busy", {127'h0, busy}, 128'h1);
    check("start_irq", {127'h0, irq}, 128'h1);

    rd(8'h10, 32'h0C0D0E0F, "rd_key0");
    rd(8'h14, 32'h08090A0B, "rd_key1");
    rd(8'h2C, 32'hFFEEDDCC, "rd_text3");
    rd(8'h20, 32'h33221100, "rd_text0");
    rd(8'h00, 32'h0000_0003, "rd_ctrl_pending");
    rd(8'h04, 32'h0, "rd_cyccnt_pending");
    rd(8'h30, 32'h0, "rd_cipher_clear");
    rd(8'h80, 32'h0, "rd_unmapped");

    // Held request: acknowledged every other cycle
    sb_q.push_back('{1'b1, 32'h0C0D0E0F, "b2b_a"});
    sb_q.push_back('{1'b1, 32'h0C0D0E0F, "b2b_b"});
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = BASE | 32'h10;
    mem_wstrb = 4'h0;
    repeat (4) @(negedge clk);
    mem_valid = 1'b0;

    // Out-of-window request: no ack, read data held
    mem_addr  = 32'h3000_0010;
    mem_valid = 1'b1;
    @(negedge clk);
    check("miss_sel", {127'h0, sel}, 128'h0);
    @(negedge clk);
    check("miss_ready", {127'h0, mem_ready}, 128'h0);
    check("miss_rdata", {96'h0, mem_rdata}, {96'h0, 32'h0C0D0E0F});
    mem_valid = 1'b0;

    // Second start while PENDING
    pulse_start(128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF, 128'h1);
    check("overrun_busy", {127'h0, busy}, 128'h1);
    rd(8'h00, 32'h0000_0007, "rd_ctrl_overrun");
    rd(8'h10, 32'h0C0D0E0F, "rd_key0_kept");
    wr(8'h00, 32'h0000_0004, 4'h1, "wr_ctrl_clr");
    rd(8'h00, 32'h0000_0003, "rd_ctrl_cleared");

    // Read-only write discarded
    wr(8'h10, 32'hFFFF_FFFF, 4'hF, "wr_key_ro");
    rd(8'h10, 32'h0C0D0E0F, "rd_key0_ro");

    // Cipher writes with byte strobes, then DONE
    wr(8'h30, 32'hAABBCCDD, 4'b0011, "wr_cipher0");
    rd(8'h30, 32'h0000CCDD, "rd_cipher0");
    wr(8'h34, 32'h11223344, 4'hF, "wr_cipher1");
    done_q.push_back({64'h0, 32'h11223344, 32'h0000CCDD});
    wr(8'h00, 32'h0000_0001, 4'h1, "wr_done");
    check("finish_busy", {127'h0, busy}, 128'h1);
    check("finish_cipherout_old", cipherout, 128'h0);
    @(negedge clk);
    check("done_pulse", {127'h0, done}, 128'h1);
    check("after_done_busy", {127'h0, busy}, 128'h0);
    check("after_done_irq", {127'h0, irq}, 128'h0);
    @(negedge clk);
    check("done_one_cycle", {127'h0, done}, 128'h0);

    // DONE outside PENDING ignored
    wr(8'h00, 32'h0000_0001, 4'h1, "wr_done_idle");
    @(negedge clk);
    check("idle_done_busy", {127'h0, busy}, 128'h0);
    rd(8'h00, 32'h0, "rd_ctrl_idle");

    // New transaction; start during FINISH sets OVERRUN and is ignored
    pulse_start(128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'h0);
    rd(8'h30, 32'h0, "rd_cipher_cleared");
    rd(8'h10, 32'h44556677, "rd_key0_new");
    wr(8'h38, 32'hDEADBEEF, 4'hF, "wr_cipher2");
    done_q.push_back({32'h0, 32'hDEADBEEF, 64'h0});
    wr(8'h00, 32'h0000_0001, 4'h1, "wr_done2");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("finish_start_busy", {127'h0, busy}, 128'h0);
    rd(8'h00, 32'h0000_0004, "rd_ctrl_finish_overrun");
    check("cipherout2", cipherout, {32'h0, 32'hDEADBEEF, 64'h0});

    // Start coincident with OVERRUN clear keeps OVERRUN
    wr(8'h00, 32'h0000_0004, 4'h1, "wr_ctrl_clr2");
    rd(8'h00, 32'h0, "rd_ctrl_clr2");
    pulse_start(128'h5, 128'h6);
    bus(8'h00, 32'h0000_0004, 4'h1, 32'h0, "wr_clr_with_start", 1'b1);
    rd(8'h00, 32'h0000_0007, "rd_ctrl_start_wins");

    // Reset mid-PENDING aborts without done
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_busy", {127'h0, busy}, 128'h0);
    check("abort_irq", {127'h0, irq}, 128'h0);
    check("abort_cipherout", cipherout, 128'h0);
    check("abort_done", {127'h0, done}, 128'h0);
    resetn = 1'b1;
    rd(8'h00, 32'h0, "rd_ctrl_abort");
    rd(8'h10, 32'h0, "rd_key0_abort");
    repeat (3) @(negedge clk);

`ifdef MAILBOX_CYCCNT_EN
    pulse_start(128'h0, 128'h0);
    repeat (8) @(negedge clk);
    done_q.push_back(128'h0);
    wr(8'h00, 32'h0000_0001, 4'h1, "wr_done_cyc");
    repeat (2) @(negedge clk);
    bus(8'h04, 32'h0, 4'h0, 32'h0, "rd_cyccnt_meas", 1'b0);
    sb_q[sb_q.size()-1].chk = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!(mem_rdata >= 32'd9 && mem_rdata <= 32'd11)) begin
      failures++;
      $display("FAIL cyccnt actual=%0d required=10", mem_rdata);
    end
`else
    rd(8'h04, 32'h0, "rd_cyccnt_absent");
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 128'(sb_q.size()), 128'h0);
    check("done_drained", 128'(done_q.size()), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pico_crypto_mailbox.md
# pico_crypto_mailbox

Memory-mapped mailbox on the PicoRV32 native memory bus, downstream of the core's data port and upstream of the CW305 crypto register bank. Accepts a start pulse from the register bank, snapshots key and plaintext for the firmware, exposes them as readable words, collects firmware-written ciphertext and returns it with a one-cycle done pulse. This lets the firmware act as the "crypto core" seen by the capture host.

## Interface
Parameters:
- BASE_ADDR, 32'h2000_0000, base of the 256-byte window; the block decodes mem_addr[31:8] == BASE_ADDR[31:8].
- KEY_WIDTH, 128, key width in bits; must be a multiple of 32 and at most 128.
- TEXT_WIDTH, 128, plaintext and ciphertext width in bits; must be a multiple of 32 and at most 128.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; also clocks the core and the bank.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  core bus request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_ready  out  1  one-cycle acknowledge for hits.
- mem_rdata  out  32  read data, valid while mem_ready is high.
- sel  out  1  combinational address hit, used by the system read mux.
- start  in  1  one-cycle request from the register bank.
- key  in  KEY_WIDTH  key from the bank.
- textin  in  TEXT_WIDTH  plaintext from the bank.
- cipherout  out  TEXT_WIDTH  ciphertext to the bank.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from an accepted start until done.
- irq  out  1  level, high in PENDING; goes to a core IRQ line.

## Operation
State machine:
- IDLE: on start, capture key and textin into shadow registers and enter PENDING.
- PENDING: the firmware reads the shadows, writes the cipher words, then writes CTRL.DONE=1. The block then enters FINISH.
- FINISH: lasts one cycle. Copies the cipher shadow to cipherout, pulses done, returns to IDLE.

Register map (word offsets):
- 0x00 CTRL/STATUS:
  - bit0: read PENDING; write 1 = DONE.
  - bit1: BUSY, read-only.
  - bit2: OVERRUN, sticky; write 1 to clear.
- 0x04 CYCCNT, read-only; see Configuration.
- 0x10–0x1C key words, read-only.
- 0x20–0x2C plaintext words, read-only.
- 0x30–0x3C cipher shadow words, read/write with byte strobes honored.
- Word n of each field holds bits [32n+31:32n]. Words beyond KEY_WIDTH or TEXT_WIDTH read 0.

Bus rules:
- Unmapped offsets read 0. Writes to read-only or unmapped offsets are acknowledged and discarded.
- CTRL writes act only if mem_wstrb[0] is set.
- CTRL.DONE written outside PENDING is ignored.
- The cipher shadow is writable in any state and is cleared on entering PENDING.

Boundary conditions:
- start outside IDLE is ignored and sets OVERRUN. This includes start in the same cycle as FINISH.
- A start and a firmware OVERRUN-clear in the same cycle leave OVERRUN set.
- When sel is low, mem_ready stays 0 and mem_rdata is unchanged.

## Timing
- Every output resets to 0, the state resets to IDLE, and all shadows reset to 0. Reset mid-transaction aborts it with no done pulse.
- Start sampled high at edge N: busy and irq are high after edge N. The shadows hold the key and textin values sampled at edge N.
- Bus access: mem_valid && sel sampled at edge N gives mem_ready=1 for exactly the cycle after edge N. mem_ready drops after edge N+1 even if mem_valid is still high, so back-to-back hits are acknowledged every other cycle.
- Read data reflects state before edge N's writes take effect.
- A DONE write accepted at edge N: the state is FINISH after N. At edge N+1, cipherout updates and done pulses high for one cycle. busy and irq fall at N+1.

## Configuration
- MAILBOX_CYCCNT_EN defined:
  - a 32-bit CYCCNT clears on entering PENDING;
  - it increments each PENDING cycle, saturating at 32'hFFFF_FFFF;
  - it holds its value in IDLE.
- Undefined: CYCCNT is absent and offset 0x04 reads 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, PENDING, FINISH);
  - the register offset constants;
  - the CTRL bit indices.
- A sub-module is natural: mailbox_regfile, holding the shadow words, byte-strobe write logic and read mux. The FSM and bus acknowledge stay in the top level.

## Test plan
- Reset with start=1 held: every output is 0. After resetn rises, the first start gives busy=1 and irq=1 on the next cycle.
- Start with key=0x000102…0F and textin=0xFFEE…00: reading 0x10 returns 0x0C0D0E0F; reading 0x2C returns 0xFFEEDDCC.
- Write 0x30 with wdata 0xAABBCCDD and wstrb 4'b0011, then write CTRL=1: one cycle later cipherout[31:0]=0x0000CCDD, done pulses once, busy=0.
- Second start while PENDING: state, snapshot and busy are unchanged; CTRL reads 0x7. Writing 0x4 to CTRL clears OVERRUN, and CTRL then reads 0x3.
- resetn pulsed low mid-PENDING: no done pulse; cipherout=0; state is IDLE.
- With MAILBOX_CYCCNT_EN, DONE written 10 cycles after start: CYCCNT reads 10 ±1 per the defined edge. Without the macro, 0x04 reads 0.
